render_sprite: RTL and testbench

Parametrised tile/sprite blitter that copies one TILE_W x TILE_H RGB565 image from tile ROM into the frame buffer at screen position (left, top).
- Runs under a start/busy/done handshake instead of free-running; the scene sequencer issues one tile per command.
- Adds colour-key transparency, horizontal/vertical flip and screen-edge clipping.
- Sits between the tile ROM (synchronous read, ROM_LAT cycles) and the frame-buffer write port.

---
 rtl/render_pkg.sv | 30 +++
 rtl/pix_delay_line.sv | 31 +++
 rtl/render_sprite.sv | 153 +++++++++++++++
 tb/tb_render_sprite.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// render_pkg: shared screen defaults, colour width, FSM encoding and pixel-tag type for render_sprite.
// Rev 1.0
`default_nettype none

package render_pkg;

  localparam int SCR_W_DEF = 640;
  localparam int SCR_H_DEF = 480;
  localparam int COLOR_W   = 16;
  localparam int COORD_W   = 11;

  localparam logic [COLOR_W-1:0] KEY_COLOR_DEF = 16'hF81F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Screen position travelling alongside an outstanding ROM read.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_t;

endpackage

`default_nettype wire

// File: rtl/pix_delay_line.sv
// pix_delay_line: DEPTH-stage shift register of pixel tags, aligned to tile-ROM read latency.
// Rev 1.0
`default_nettype none

module pix_delay_line
  import render_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  pix_t pix_i,
  output pix_t pix_o
);

  pix_t stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= pix_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign pix_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/render_sprite.sv
// render_sprite: tile blitter copying a TILE_W x TILE_H RGB565 tile into the frame buffer.
// Rev 1.0
`default_nettype none

module render_sprite
  import render_pkg::*;
#(
  parameter int                 TILE_W    = 32,
  parameter int                 TILE_H    = 32,
  parameter int                 SCR_W     = SCR_W_DEF,
  parameter int                 SCR_H     = SCR_H_DEF,
  parameter int                 ADDR_W    = 19,
  parameter int                 ROM_LAT   = 1,
  parameter bit                 KEY_EN    = 1'b1,
  parameter logic [COLOR_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [ADDR_W-1:0]  tile_addr,
  input  logic [9:0]         top,
  input  logic [9:0]         left,
  input  logic               flip_x,
  input  logic               flip_y,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [ADDR_W-1:0]  dst_addr,
  output logic [COLOR_W-1:0] dst_data,
  output logic               dst_wr
);

  localparam int CW    = $clog2(TILE_W);
  localparam int RW    = $clog2(TILE_H);
  localparam int CNT_W = CW + RW;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROM_LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q;
  logic [9:0]         top_q, left_q;
  logic               flip_x_q, flip_y_q;
  logic               busy_q, done_q;
  logic               dst_wr_q, dst_wr_d;
  logic [ADDR_W-1:0]  dst_addr_q;
  logic [COLOR_W-1:0] dst_data_q;
  logic [CW-1:0]      col, col_src;
  logic [RW-1:0]      row, row_src;
  logic               accept;
  pix_t               pix_in, pix_out;

  // Tile dimensions are powers of two, so mirroring is bit inversion and the
  // row-major offset is a plain concatenation.
  assign col      = cnt_q[CW-1:0];
  assign row      = cnt_q[CNT_W-1:CW];
  assign col_src  = flip_x_q ? ~col : col;
  assign row_src  = flip_y_q ? ~row : row;
  assign rom_addr = base_q + ADDR_W'({row_src, col_src});
  assign accept   = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_in.valid = (state_q == ST_ISSUE);
    pix_in.x     = {1'b0, left_q} + COORD_W'(col);
    pix_in.y     = {1'b0, top_q} + COORD_W'(row);
  end

  pix_delay_line #(
    .DEPTH (ROM_LAT)
  ) u_delay (
    .clk_i  (clk),
    .rst_ni (rstn),
    .pix_i  (pix_in),
    .pix_o  (pix_out)
  );

  always_comb begin
    dst_wr_d = pix_out.valid
            && (int'(pix_out.x) < SCR_W)
            && (int'(pix_out.y) < SCR_H)
            && !(KEY_EN && (rom_data == KEY_COLOR));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      top_q      <= '0;
      left_q     <= '0;
      flip_x_q   <= 1'b0;
      flip_y_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dst_wr_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
      done_q   <= (state_q == ST_DONE);
      dst_wr_q <= dst_wr_d;
      if (accept) begin
        base_q   <= tile_addr;
        top_q    <= top;
        left_q   <= left;
        flip_x_q <= flip_x;
        flip_y_q <= flip_y;
      end
      if (dst_wr_d) begin
        dst_addr_q <= ADDR_W'(int'(pix_out.y) * SCR_W + int'(pix_out.x));
        dst_data_q <= rom_data;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dst_wr   = dst_wr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;

endmodule

`default_nettype wire

// File: tb/tb_render_sprite.sv
// tb_render_sprite: directed checks of render_sprite with ROM_LAT=1/KEY_EN=1 and ROM_LAT=3/KEY_EN=0 instances.
// Rev 1.0
`default_nettype none

module tb_render_sprite;

  localparam int N = 1024;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [18:0] tile_addr = '0;
  logic [9:0]  top = '0;
  logic [9:0]  left = '0;
  logic        flip_x = 1'b0;
  logic        flip_y = 1'b0;

  logic        busy_a, done_a, dst_wr_a, busy_b, done_b, dst_wr_b;
  logic [18:0] rom_addr_a, dst_addr_a, rom_addr_b, dst_addr_b;
  logic [15:0] rom_data_a, dst_data_a, rom_data_b, dst_data_b;
  logic [15:0] mem [0:2047];
  logic [15:0] rom_b_p [0:2];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  wr_t  wq_a[$], wq_b[$];
  int   dq_a[$], dq_b[$], bq_a[$];
  logic busy_a_prev = 1'b0;

  render_sprite #(.ROM_LAT(1), .KEY_EN(1'b1)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start), .tile_addr(tile_addr), .top(top), .left(left),
    .flip_x(flip_x), .flip_y(flip_y), .busy(busy_a), .done(done_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .dst_addr(dst_addr_a), .dst_data(dst_data_a), .dst_wr(dst_wr_a)
  );

  render_sprite #(.ROM_LAT(3), .KEY_EN(1'b0)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start), .tile_addr(tile_addr), .top(top), .left(left),
    .flip_x(flip_x), .flip_y(flip_y), .busy(busy_b), .done(done_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .dst_addr(dst_addr_b), .dst_data(dst_data_b), .dst_wr(dst_wr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data_a <= mem[rom_addr_a[10:0]];

  always @(posedge clk) begin
    rom_b_p[0] <= mem[rom_addr_b[10:0]];
    rom_b_p[1] <= rom_b_p[0];
    rom_b_p[2] <= rom_b_p[1];
  end
  assign rom_data_b = rom_b_p[2];

  always @(negedge clk) begin
    if (dst_wr_a === 1'b1) wq_a.push_back('{cyc, int'(dst_addr_a), int'(dst_data_a)});
    if (dst_wr_b === 1'b1) wq_b.push_back('{cyc, int'(dst_addr_b), int'(dst_data_b)});
    if (done_a === 1'b1) dq_a.push_back(cyc);
    if (done_b === 1'b1) dq_b.push_back(cyc);
    if (busy_a !== busy_a_prev) bq_a.push_back(cyc);
    busy_a_prev <= busy_a;
  end

  // t0 is the cycle count seen at the first falling edge after the accepting edge.
  task automatic issue(input logic [9:0] t, input logic [9:0] l, input logic fx, input logic fy,
                       output int t0);
    @(negedge clk);
    tile_addr = '0; top = t; left = l; flip_x = fx; flip_y = fy; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({busy_a, done_a, dst_wr_a} !== 3'b000) begin failures++;
      $display("FAIL reset_flags: got %b expected 000", {busy_a, done_a, dst_wr_a}); end
    checks++; if (dst_addr_a !== 19'd0) begin failures++;
      $display("FAIL reset_dst_addr: got %0d expected 0", dst_addr_a); end
    checks++; if (dst_data_a !== 16'd0) begin failures++;
      $display("FAIL reset_dst_data: got %0d expected 0", dst_data_a); end
    checks++; if (rom_addr_a !== 19'd0) begin failures++;
      $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr_a); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy_a, done_a, dst_wr_a, busy_b} !== 4'b0000) begin failures++;
      $display("FAIL idle_flags: got %b expected 0000", {busy_a, done_a, dst_wr_a, busy_b}); end
  endtask

  task automatic test_basic();
    int t0, n, v, d643;
    int na = wq_a.size(), nwb = wq_b.size(), nd = dq_a.size(), ndb = dq_b.size(), nb = bq_a.size();
    d643 = -1;
    issue(10'd0, 10'd0, 1'b0, 1'b0, t0);
    repeat (1035) @(negedge clk);
    n = wq_a.size() - na;
    checks++; if (n != N) begin failures++;
      $display("FAIL basic_wr_count: got %0d expected %0d", n, N); end
    v = (n > 0) ? wq_a[na].cyc - t0 : -1;
    checks++; if (v != 2) begin failures++;
      $display("FAIL basic_first_wr_cycle: got %0d expected 2", v); end
    v = (n > 0) ? wq_a[wq_a.size()-1].cyc - t0 : -1;
    checks++; if (v != 1025) begin failures++;
      $display("FAIL basic_last_wr_cycle: got %0d expected 1025", v); end
    for (int i = na; i < wq_a.size(); i++) if (wq_a[i].addr == 643) d643 = wq_a[i].data;
    checks++; if (d643 != 35) begin failures++;
      $display("FAIL basic_pixel_3_1: got %0d expected 35", d643); end
    v = dq_a.size() - nd;
    checks++; if (v != 1) begin failures++;
      $display("FAIL basic_done_count: got %0d expected 1", v); end
    v = (dq_a.size() > nd) ? dq_a[nd] - t0 : -1;
    checks++; if (v != 1026) begin failures++;
      $display("FAIL basic_done_cycle: got %0d expected 1026", v); end
    v = (bq_a.size() == nb + 2) ? bq_a[nb] - t0 : -1;
    checks++; if (v != 1) begin failures++;
      $display("FAIL basic_busy_rise: got %0d expected 1", v); end
    v = (bq_a.size() == nb + 2) ? bq_a[nb+1] - t0 : -1;
    checks++; if (v != 1026) begin failures++;
      $display("FAIL basic_busy_fall: got %0d expected 1026", v); end
    v = (wq_b.size() > nwb) ? wq_b[nwb].cyc - t0 : -1;
    checks++; if (v != 4) begin failures++;
      $display("FAIL lat3_first_wr_cycle: got %0d expected 4", v); end
    v = (dq_b.size() > ndb) ? dq_b[ndb] - t0 : -1;
    checks++; if (v != 1028) begin failures++;
      $display("FAIL lat3_done_cycle: got %0d expected 1028", v); end
  endtask

  task automatic test_flip();
    int t0, n, v;
    int na = wq_a.size();
    issue(10'd0, 10'd0, 1'b1, 1'b1, t0);
    repeat (1035) @(negedge clk);
    n = wq_a.size() - na;
    v = (n > 0) ? wq_a[na].addr : -1;
    checks++; if (v != 0) begin failures++;
      $display("FAIL flip_first_addr: got %0d expected 0", v); end
    v = (n > 0) ? wq_a[na].data : -1;
    checks++; if (v != 1023) begin failures++;
      $display("FAIL flip_first_data: got %0d expected 1023", v); end
    v = (n > 0) ? wq_a[wq_a.size()-1].addr : -1;
    checks++; if (v != 31*640+31) begin failures++;
      $display("FAIL flip_last_addr: got %0d expected %0d", v, 31*640+31); end
    v = (n > 0) ? wq_a[wq_a.size()-1].data : -1;
    checks++; if (v != 0) begin failures++;
      $display("FAIL flip_last_data: got %0d expected 0", v); end
  endtask

  task automatic test_color_key();
    int t0, n, hits;
    int na = wq_a.size(), nwb = wq_b.size();
    hits = 0;
    mem[5] = 16'hF81F;
    issue(10'd0, 10'd0, 1'b0, 1'b0, t0);
    repeat (1035) @(negedge clk);
    mem[5] = 16'd5;
    n = wq_a.size() - na;
    checks++; if (n != 1023) begin failures++;
      $display("FAIL key_wr_count: got %0d expected 1023", n); end
    for (int i = na; i < wq_a.size(); i++) if (wq_a[i].addr == 5) hits++;
    checks++; if (hits != 0) begin failures++;
      $display("FAIL key_addr5_writes: got %0d expected 0", hits); end
    n = wq_b.size() - nwb;
    checks++; if (n != N) begin failures++;
      $display("FAIL nokey_wr_count: got %0d expected %0d", n, N); end
  endtask

  task automatic test_clip();
    int t0, n, v, bad;
    int na = wq_a.size(), nwb = wq_b.size(), nd;
    bad = 0;
    issue(10'd470, 10'd620, 1'b0, 1'b0, t0);
    repeat (1035) @(negedge clk);
    n = wq_a.size() - na;
    checks++; if (n != 200) begin failures++;
      $display("FAIL clip_wr_count: got %0d expected 200", n); end
    for (int i = na; i < wq_a.size(); i++) if (wq_a[i].addr >= 307200) bad++;
    checks++; if (bad != 0) begin failures++;
      $display("FAIL clip_offscreen_writes: got %0d expected 0", bad); end
    v = (n > 0) ? wq_a[na].addr : -1;
    checks++; if (v != 470*640+620) begin failures++;
      $display("FAIL clip_first_addr: got %0d expected %0d", v, 470*640+620); end
    n = wq_b.size() - nwb;
    checks++; if (n != 200) begin failures++;
      $display("FAIL clip_wr_count_lat3: got %0d expected 200", n); end
    na = wq_a.size();
    nd = dq_a.size();
    issue(10'd0, 10'd700, 1'b0, 1'b0, t0);
    repeat (1035) @(negedge clk);
    n = wq_a.size() - na;
    checks++; if (n != 0) begin failures++;
      $display("FAIL fullclip_wr_count: got %0d expected 0", n); end
    v = (dq_a.size() > nd) ? dq_a[nd] - t0 : -1;
    checks++; if (v != 1026) begin failures++;
      $display("FAIL fullclip_done_cycle: got %0d expected 1026", v); end
  endtask

  task automatic test_back_to_back();
    int t0, n, v;
    int na = wq_a.size(), nd = dq_a.size(), ndb = dq_b.size();
    issue(10'd0, 10'd0, 1'b0, 1'b0, t0);
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (524) @(negedge clk);
    // Held across the DONE cycle and the first IDLE cycle of the ROM_LAT=1 instance.
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (1035) @(negedge clk);
    v = dq_a.size() - nd;
    checks++; if (v != 2) begin failures++;
      $display("FAIL b2b_done_count: got %0d expected 2", v); end
    v = (dq_a.size() > nd + 1) ? dq_a[nd+1] - t0 : -1;
    checks++; if (v != 2053) begin failures++;
      $display("FAIL b2b_second_done_cycle: got %0d expected 2053", v); end
    n = wq_a.size() - na;
    checks++; if (n != 2 * N) begin failures++;
      $display("FAIL b2b_wr_count: got %0d expected %0d", n, 2 * N); end
    v = dq_b.size() - ndb;
    checks++; if (v != 1) begin failures++;
      $display("FAIL b2b_lat3_done_count: got %0d expected 1", v); end
  endtask

  task automatic test_reset_mid();
    int t0, n, v, late;
    int na = wq_a.size(), nd = dq_a.size(), ndb = dq_b.size();
    late = 0;
    issue(10'd0, 10'd0, 1'b0, 1'b0, t0);
    repeat (500) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if ({dst_wr_a, busy_a, busy_b} !== 3'b000) begin failures++;
      $display("FAIL midreset_flags: got %b expected 000", {dst_wr_a, busy_a, busy_b}); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (600) @(negedge clk);
    for (int i = na; i < wq_a.size(); i++) if (wq_a[i].cyc > t0 + 500) late++;
    checks++; if (late != 0) begin failures++;
      $display("FAIL midreset_late_writes: got %0d expected 0", late); end
    v = (dq_a.size() - nd) + (dq_b.size() - ndb);
    checks++; if (v != 0) begin failures++;
      $display("FAIL midreset_done_count: got %0d expected 0", v); end
    na = wq_a.size();
    nd = dq_a.size();
    issue(10'd0, 10'd0, 1'b0, 1'b0, t0);
    repeat (1035) @(negedge clk);
    n = wq_a.size() - na;
    checks++; if (n != N) begin failures++;
      $display("FAIL postreset_wr_count: got %0d expected %0d", n, N); end
    v = (dq_a.size() > nd) ? dq_a[nd] - t0 : -1;
    checks++; if (v != 1026) begin failures++;
      $display("FAIL postreset_done_cycle: got %0d expected 1026", v); end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = 16'(k);
    test_reset();
    test_basic();
    test_flip();
    test_color_key();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
